// File: rtl/inst_queue_ds.sv
// inst_queue_ds: dual-port fetch-to-decode instruction queue with branch delay-slot tracking across flushes
module inst_queue_ds #(
  parameter int DEPTH = 16,
  parameter int DATA_W = 32,
  parameter int PC_W = 32,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              flush_keep_slot,
  input  logic              write_en1,
  input  logic              write_en2,
  input  logic [DATA_W-1:0] write_data1,
  input  logic [DATA_W-1:0] write_data2,
  input  logic [PC_W-1:0]   write_pc1,
  input  logic [PC_W-1:0]   write_pc2,
  input  logic              read_en1,
  input  logic              read_en2,
  input  logic              issue1_is_branch,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [PC_W-1:0]   pc_out1,
  output logic [PC_W-1:0]   pc_out2,
  output logic              valid1,
  output logic              valid2,
  output logic              delay_slot_out1,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              almost_empty,
  output logic              full,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {NORMAL, HOLD, WAIT_SLOT} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PC_W-1:0]   mem_p [DEPTH];
  logic [AW-1:0]     rptr, wptr, rptr1;
  logic [DATA_W-1:0] hold_d;
  logic [PC_W-1:0]   hold_p;
  logic slot_flag, nrm, hld, q_v1, q_v2, keep, acc1, acc2, r1, r2, cap_q, cap_w, ovf_set;
  assign nrm = state == NORMAL;
  assign hld = state == HOLD;
  assign rptr1 = rptr + AW'(1);
  assign q_v1 = count != '0;
  assign q_v2 = count > CW'(1);
  assign keep = nrm && flush && flush_keep_slot;
  // queue writes only happen outside flush and outside WAIT_SLOT; free space is judged on the pre-update count
  assign acc1 = !flush && state != WAIT_SLOT && write_en1 && count < CW'(DEPTH);
  assign acc2 = acc1 && write_en2 && count < CW'(DEPTH - 1);
  assign ovf_set = !flush && state != WAIT_SLOT && write_en1 && (!acc1 || (write_en2 && !acc2));
  assign r1 = nrm && read_en1 && q_v1;
  assign r2 = r1 && read_en2 && q_v2;
  assign cap_q = keep && q_v2;
  assign cap_w = (keep && !q_v2 && write_en1) || (state == WAIT_SLOT && !flush && write_en1);
  always_comb begin
    state_n = flush ? (keep ? ((cap_q || cap_w) ? HOLD : WAIT_SLOT) : NORMAL) :
              (state == WAIT_SLOT && write_en1) ? HOLD :
              (hld && read_en1) ? NORMAL : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NORMAL;
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      slot_flag <= 1'b0;
      hold_d <= '0;
      hold_p <= '0;
    end else begin
      state <= state_n;
      overflow <= overflow | ovf_set;
      if (acc1) begin
        mem_d[wptr] <= write_data1;
        mem_p[wptr] <= write_pc1;
      end
      if (acc2) begin
        mem_d[wptr + AW'(1)] <= write_data2;
        mem_p[wptr + AW'(1)] <= write_pc2;
      end
      if (flush) begin
        rptr <= '0;
        wptr <= '0;
        count <= '0;
      end else begin
        rptr <= rptr + AW'(r1) + AW'(r2);
        wptr <= wptr + AW'(acc1) + AW'(acc2);
        count <= count + CW'(acc1) + CW'(acc2) - CW'(r1) - CW'(r2);
      end
      slot_flag <= (flush || !nrm) ? 1'b0 : r1 ? (!r2 && issue1_is_branch) : slot_flag;
      if (cap_q) begin
        hold_d <= mem_d[rptr1];
        hold_p <= mem_p[rptr1];
      end else if (cap_w) begin
        hold_d <= write_data1;
        hold_p <= write_pc1;
      end
    end
  end
  assign valid1 = hld || (nrm && q_v1);
  assign valid2 = nrm && q_v2;
  assign data_out1 = hld ? hold_d : valid1 ? mem_d[rptr] : '0;
  assign pc_out1 = hld ? hold_p : valid1 ? mem_p[rptr] : '0;
  assign data_out2 = valid2 ? mem_d[rptr1] : '0;
  assign pc_out2 = valid2 ? mem_p[rptr1] : '0;
  assign delay_slot_out1 = hld || (nrm && slot_flag);
  assign empty = count == '0;
  assign almost_empty = count == CW'(1);
  assign full = count >= CW'(DEPTH - 2);
endmodule

// File: tb/tb_inst_queue_ds.sv
// tb_inst_queue_ds: randomized and directed checks of inst_queue_ds against a queue-based reference model
module tb_inst_queue_ds;
  localparam int DEPTH = 16;
  logic clk = 0, rst, flush, keep, we1, we2, re1, re2, br;
  logic [31:0] wd1, wd2, wp1, wp2, d1, d2, p1, p2;
  logic v1, v2, ds, empty, aempty, full, ovf;
  logic [4:0] count;
  typedef struct packed {logic [31:0] d; logic [31:0] p;} ent_t;
  ent_t q[$];
  ent_t hold;
  int mode;
  logic slot, movf;
  int vectors = 0, errs = 0;
  always #5 clk = ~clk;
  inst_queue_ds dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_keep_slot(keep),
    .write_en1(we1), .write_en2(we2), .write_data1(wd1), .write_data2(wd2),
    .write_pc1(wp1), .write_pc2(wp2), .read_en1(re1), .read_en2(re2),
    .issue1_is_branch(br), .data_out1(d1), .data_out2(d2), .pc_out1(p1), .pc_out2(p2),
    .valid1(v1), .valid2(v2), .delay_slot_out1(ds), .count(count), .empty(empty),
    .almost_empty(aempty), .full(full), .overflow(ovf)
  );
  task idle();
    rst = 0; flush = 0; keep = 0; we1 = 0; we2 = 0; re1 = 0; re2 = 0; br = 0;
    wd1 = 0; wd2 = 0; wp1 = 0; wp2 = 0;
  endtask
  task wr(input int n, input logic [31:0] pc);
    idle();
    we1 = n > 0; we2 = n > 1; wp1 = pc; wp2 = pc + 4;
    wd1 = $urandom; wd2 = $urandom;
  endtask
  // model: mode 0 = normal, 1 = holding a captured slot, 2 = waiting for the slot to be fetched
  task step();
    int free, n;
    bit a1;
    if (rst) begin
      q.delete(); mode = 0; slot = 0; movf = 0;
    end else if (flush) begin
      if (mode == 0 && keep && q.size() >= 2) begin hold = q[1]; mode = 1; end
      else if (mode == 0 && keep && we1) begin hold = '{d: wd1, p: wp1}; mode = 1; end
      else mode = (mode == 0 && keep) ? 2 : 0;
      q.delete(); slot = 0;
    end else if (mode == 2) begin
      if (we1) begin hold = '{d: wd1, p: wp1}; mode = 1; end
    end else begin
      free = DEPTH - q.size(); n = 0;
      if (mode == 0) begin
        if (re1 && q.size() >= 1) n = 1;
        if (n == 1 && re2 && q.size() >= 2) n = 2;
        if (n == 1) slot = br; else if (n == 2) slot = 0;
      end else if (re1) mode = 0;
      repeat (n) void'(q.pop_front());
      a1 = we1 && free >= 1;
      if (a1) q.push_back('{d: wd1, p: wp1});
      if (we1 && !a1) movf = 1;
      if (we1 && we2) begin
        if (a1 && free >= 2) q.push_back('{d: wd2, p: wp2}); else movf = 1;
      end
    end
    @(posedge clk); #1;
  endtask
  task test_reset();
    idle(); rst = 1; step(); step(); idle();
    vectors++;
    if ({d1, d2, p1, p2, v1, v2, ds, count, empty, full, ovf} !== {128'h0, 3'b000, 5'd0, 1'b1, 1'b0, 1'b0}) begin
      errs++; $display("FAIL reset: got d1=%h d2=%h p1=%h p2=%h v=%b%b ds=%b cnt=%0d e=%b f=%b o=%b, want all zero, empty=1", d1, d2, p1, p2, v1, v2, ds, count, empty, full, ovf);
    end
  endtask
  task test_basic();
    wr(2, 32'h1000); step();
    vectors++;
    if ({p1, p2, count, v2, aempty} !== {32'h1000, 32'h1004, 5'd2, 1'b1, 1'b0}) begin
      errs++; $display("FAIL basic_pair1: got p1=%h p2=%h cnt=%0d v2=%b ae=%b, want 1000 1004 2 1 0", p1, p2, count, v2, aempty);
    end
    wr(2, 32'h1008); step();
    vectors++;
    if (count !== 5'd4 || p1 !== 32'h1000) begin errs++; $display("FAIL basic_pair2: got cnt=%0d p1=%h, want 4 1000", count, p1); end
    idle(); re1 = 1; re2 = 1; step();
    vectors++;
    if ({p1, p2, count} !== {32'h1008, 32'h100C, 5'd2}) begin errs++; $display("FAIL basic_dual_read: got p1=%h p2=%h cnt=%0d, want 1008 100c 2", p1, p2, count); end
    idle(); re1 = 1; step();
    vectors++;
    if ({p1, v2, count, aempty, empty} !== {32'h100C, 1'b0, 5'd1, 1'b1, 1'b0}) begin errs++; $display("FAIL basic_almost_empty: got p1=%h v2=%b cnt=%0d ae=%b e=%b, want 100c 0 1 1 0", p1, v2, count, aempty, empty); end
    idle(); re1 = 1; re2 = 1; step();
    vectors++;
    if ({v1, count, aempty, empty, p1} !== {1'b0, 5'd0, 1'b0, 1'b1, 32'h0}) begin errs++; $display("FAIL basic_drain: got v1=%b cnt=%0d ae=%b e=%b p1=%h, want 0 0 0 1 0", v1, count, aempty, empty, p1); end
  endtask
  task test_branch();
    wr(2, 32'h40); step();
    wr(2, 32'h48); step();
    idle(); re1 = 1; br = 1; step();
    vectors++;
    if ({ds, p1} !== {1'b1, 32'h44}) begin errs++; $display("FAIL branch_single: got ds=%b p1=%h, want 1 44", ds, p1); end
    idle(); re1 = 1; step();
    vectors++;
    if ({ds, p1} !== {1'b0, 32'h48}) begin errs++; $display("FAIL branch_slot_done: got ds=%b p1=%h, want 0 48", ds, p1); end
    idle(); re1 = 1; re2 = 1; br = 1; step();
    vectors++;
    if ({ds, count} !== {1'b0, 5'd0}) begin errs++; $display("FAIL branch_dual: got ds=%b cnt=%0d, want 0 0", ds, count); end
  endtask
  task test_full();
    for (int i = 0; i < 8; i++) begin
      wr(2, 32'h100 + 8 * i); step();
      vectors++;
      if ({count, full} !== {5'(2 * i + 2), i >= 6}) begin errs++; $display("FAIL full_fill%0d: got cnt=%0d full=%b, want %0d %b", i, count, full, 2 * i + 2, i >= 6); end
    end
    wr(1, 32'h200); step();
    vectors++;
    if ({count, ovf, full} !== {5'd16, 1'b1, 1'b1}) begin errs++; $display("FAIL full_overflow: got cnt=%0d ovf=%b full=%b, want 16 1 1", count, ovf, full); end
    wr(1, 32'h204); re1 = 1; step();
    vectors++;
    if ({count, p1} !== {5'd15, 32'h104}) begin errs++; $display("FAIL full_rw: got cnt=%0d p1=%h, want 15 104", count, p1); end
  endtask
  task test_wait();
    idle(); flush = 1; step();
    vectors++;
    if ({count, empty, ovf, v1} !== {5'd0, 1'b1, 1'b1, 1'b0}) begin errs++; $display("FAIL flush_plain: got cnt=%0d e=%b ovf=%b v1=%b, want 0 1 1 0", count, empty, ovf, v1); end
    wr(1, 32'h2F00); step();
    idle(); flush = 1; keep = 1; step();
    vectors++;
    if ({v1, v2, ds, count} !== {1'b0, 1'b0, 1'b0, 5'd0}) begin errs++; $display("FAIL wait_slot: got v1=%b v2=%b ds=%b cnt=%0d, want 0 0 0 0", v1, v2, ds, count); end
    wr(2, 32'h3000); step();
    vectors++;
    if ({v1, ds, p1, d1, v2, count} !== {1'b1, 1'b1, 32'h3000, hold.d, 1'b0, 5'd0}) begin errs++; $display("FAIL wait_capture: got v1=%b ds=%b p1=%h d1=%h v2=%b cnt=%0d, want 1 1 3000 %h 0 0", v1, ds, p1, d1, v2, count, hold.d); end
    idle(); re1 = 1; step();
    idle(); flush = 1; keep = 1; step();
    idle(); rst = 1; step(); idle();
    vectors++;
    if ({v1, ds, empty, ovf} !== {1'b0, 1'b0, 1'b1, 1'b0}) begin errs++; $display("FAIL wait_reset: got v1=%b ds=%b e=%b ovf=%b, want 0 0 1 0", v1, ds, empty, ovf); end
  endtask
  task test_keep3();
    wr(2, 32'h2000); step();
    wr(1, 32'h2008); step();
    idle(); flush = 1; keep = 1; re1 = 1; br = 1; step();
    vectors++;
    if ({p1, d1, v1, ds, v2, count} !== {32'h2004, hold.d, 1'b1, 1'b1, 1'b0, 5'd0}) begin errs++; $display("FAIL keep3_hold: got p1=%h d1=%h v1=%b ds=%b v2=%b cnt=%0d, want 2004 %h 1 1 0 0", p1, d1, v1, ds, v2, count, hold.d); end
    idle(); re1 = 1; re2 = 1; step();
    vectors++;
    if ({v1, ds, empty} !== {1'b0, 1'b0, 1'b1}) begin errs++; $display("FAIL keep3_release: got v1=%b ds=%b e=%b, want 0 0 1", v1, ds, empty); end
  endtask
  task test_random();
    logic [31:0] pc = 32'h8000;
    logic e_v1, e_v2, e_ds;
    logic [31:0] e_d1, e_p1, e_d2, e_p2;
    for (int i = 0; i < 400; i++) begin
      idle();
      flush = $urandom_range(0, 24) == 0; keep = $urandom_range(0, 1);
      we1 = $urandom_range(0, 2) != 0; we2 = $urandom_range(0, 1);
      re1 = $urandom_range(0, 2) != 0; re2 = $urandom_range(0, 1); br = $urandom_range(0, 1);
      wd1 = $urandom; wd2 = $urandom; wp1 = pc; wp2 = pc + 4; pc += 8;
      step();
      e_v1 = mode == 1 || (mode == 0 && q.size() >= 1);
      e_v2 = mode == 0 && q.size() >= 2;
      e_ds = mode == 1 || (mode == 0 && slot);
      e_d1 = mode == 1 ? hold.d : e_v1 ? q[0].d : 32'h0;
      e_p1 = mode == 1 ? hold.p : e_v1 ? q[0].p : 32'h0;
      e_d2 = e_v2 ? q[1].d : 32'h0;
      e_p2 = e_v2 ? q[1].p : 32'h0;
      vectors++;
      if ({v1, v2, ds, ovf, count, empty, aempty, full, d1, p1, d2, p2} !==
          {e_v1, e_v2, e_ds, movf, 5'(q.size()), q.size() == 0, q.size() == 1, q.size() >= DEPTH - 2, e_d1, e_p1, e_d2, e_p2}) begin
        errs++;
        $display("FAIL random%0d: got v=%b%b ds=%b o=%b cnt=%0d e/ae/f=%b%b%b %h %h %h %h, want v=%b%b ds=%b o=%b cnt=%0d %h %h %h %h",
                 i, v1, v2, ds, ovf, count, empty, aempty, full, d1, p1, d2, p2, e_v1, e_v2, e_ds, movf, q.size(), e_d1, e_p1, e_d2, e_p2);
      end
    end
  endtask
  initial begin
    idle();
    test_reset();
    test_basic();
    test_branch();
    test_full();
    test_wait();
    test_keep3();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
